// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types, widths and helpers for the ADC channel sequencer
//
// Contents:
//   ADC_DATA_W  - default ADC result width
//   SEQ_CNT_W   - width of the shared startup/settle/timeout counter
//   seq_state_t - sequencer state encoding
//   clog2()     - constant ceil(log2) helper, minimum result 1

package adc_seq_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int SEQ_CNT_W  = 16;

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        SETTLE,
        CONVERT,
        DELIVER
    } seq_state_t;

    // Never returns 0 so that a select bus always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// rtl/rr_arbiter_pick.sv - combinational round-robin winner search
//
// Ports:
//   req    in   NUM_REQ  request vector, bit i = requester i
//   ptr    in   IDX_W    last served index; search starts at ptr+1
//   winner out  IDX_W    index of the first set request after ptr (wrapping)
//   found  out  1        at least one request is set

module rr_arbiter_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Offsets 1..NUM_REQ visit every requester once, ptr itself last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// rtl/adc_channel_sequencer.sv - round-robin sharing of one ADC between NUM_CH requesters
//
// Optional build macro: ADC_SEQ_AVG4_EN (4 conversions per grant, result = sum>>2)
//
// Ports:
//   clk_1M       in   1          system clock
//   rst_n        in   1          synchronous active-low reset
//   ch_req       in   NUM_CH     level request per channel
//   ch_grant     out  NUM_CH     one-hot grant, high only in the ch_valid cycle
//   ch_valid     out  1          one-cycle result strobe
//   ch_data      out  DATA_W     last delivered result, held
//   adc_mux_sel  out  clog2      analog mux select
//   adc_start    out  1          one-cycle conversion start
//   adc_done     in   1          conversion complete pulse
//   adc_data     in   DATA_W     conversion result, valid with adc_done
//   err_clr      in   1          clears timeout_err
//   timeout_err  out  1          sticky conversion timeout flag
//   busy         out  1          high in every state except IDLE

module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = ADC_DATA_W,
    parameter int STARTUP_CYC = 250,
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk_1M,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_req,
    output logic [NUM_CH-1:0]         ch_grant,
    output logic                      ch_valid,
    output logic [DATA_W-1:0]         ch_data,
    output logic [clog2(NUM_CH)-1:0]  adc_mux_sel,
    output logic                      adc_start,
    input  logic                      adc_done,
    input  logic [DATA_W-1:0]         adc_data,
    input  logic                      err_clr,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int SEL_W = clog2(NUM_CH);

    seq_state_t           state;
    logic [SEQ_CNT_W-1:0] cnt;
    logic [SEL_W-1:0]     winner;
    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     pick;
    logic                 pick_found;

`ifdef ADC_SEQ_AVG4_EN
    logic [DATA_W+1:0]    acc;
    logic [DATA_W+1:0]    acc_next;
    logic [1:0]           conv_idx;

    assign acc_next = acc + {2'b00, adc_data};
`endif

    rr_arbiter_pick #(
        .NUM_REQ (NUM_CH),
        .IDX_W   (SEL_W)
    ) u_pick (
        .req     (ch_req),
        .ptr     (ptr),
        .winner  (pick),
        .found   (pick_found)
    );

    always_ff @(posedge clk_1M) begin
        if (!rst_n) begin
            state       <= STARTUP;
            cnt         <= '0;
            winner      <= '0;
            ptr         <= SEL_W'(NUM_CH - 1);
            ch_grant    <= '0;
            ch_valid    <= 1'b0;
            ch_data     <= '0;
            adc_mux_sel <= '0;
            adc_start   <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
`ifdef ADC_SEQ_AVG4_EN
            acc         <= '0;
            conv_idx    <= '0;
`endif
        end else begin
            adc_start <= 1'b0;
            ch_valid  <= 1'b0;
            ch_grant  <= '0;
            busy      <= 1'b1;

            // A timeout set later in this block overrides the clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                STARTUP: begin
                    if (cnt == SEQ_CNT_W'(STARTUP_CYC - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (pick_found) begin
                        winner      <= pick;
                        adc_mux_sel <= pick;
                        cnt         <= '0;
                        state       <= SETTLE;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (cnt == SEQ_CNT_W'(SETTLE_CYC - 1)) begin
                        state     <= CONVERT;
                        cnt       <= '0;
                        adc_start <= 1'b1;
`ifdef ADC_SEQ_AVG4_EN
                        acc       <= '0;
                        conv_idx  <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                CONVERT: begin
                    cnt <= cnt + 1'b1;
                    // adc_start is high only in the first cycle of each
                    // conversion, so a done pulse alongside it is dropped.
                    if (!adc_start && adc_done) begin
`ifdef ADC_SEQ_AVG4_EN
                        if (conv_idx == 2'd3) begin
                            ch_data  <= acc_next[DATA_W+1:2];
                            ch_valid <= 1'b1;
                            ch_grant <= NUM_CH'(1) << winner;
                            state    <= DELIVER;
                        end else begin
                            acc       <= acc_next;
                            conv_idx  <= conv_idx + 2'd1;
                            adc_start <= 1'b1;
                            cnt       <= '0;
                        end
`else
                        ch_data  <= adc_data;
                        ch_valid <= 1'b1;
                        ch_grant <= NUM_CH'(1) << winner;
                        state    <= DELIVER;
`endif
                    end else if (cnt == SEQ_CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Moving the pointer to the failed channel lets the
                        // other pending channels go first next time.
                        timeout_err <= 1'b1;
                        ptr         <= winner;
                        cnt         <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end

                DELIVER: begin
                    ptr   <= winner;
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb/tb_adc_channel_sequencer.sv - scoreboard testbench for adc_channel_sequencer
`timescale 1ns/1ps

module tb_adc_channel_sequencer;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 12;
`ifdef ADC_SEQ_AVG4_EN
    localparam int N_CONV = 4;
`else
    localparam int N_CONV = 1;
`endif

    logic              clk_1M;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_req;
    logic [NUM_CH-1:0] ch_grant;
    logic              ch_valid;
    logic [DATA_W-1:0] ch_data;
    logic [1:0]        adc_mux_sel;
    logic              adc_start;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              err_clr;
    logic              timeout_err;
    logic              busy;

    adc_channel_sequencer #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .STARTUP_CYC (250),
        .SETTLE_CYC  (3),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_1M      (clk_1M),
        .rst_n       (rst_n),
        .ch_req      (ch_req),
        .ch_grant    (ch_grant),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .adc_mux_sel (adc_mux_sel),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc;

    // ADC model state
    bit                adc_en;
    int                adc_delay;
    logic [DATA_W-1:0] adc_q[$];
    int                start_cnt;
    int                start_cyc;
    logic [1:0]        start_sel_q[$];
    int                cd;

    // Delivery monitor and scoreboard
    logic [NUM_CH-1:0] obs_grant_q[$];
    logic [DATA_W-1:0] obs_data_q[$];
    int                valid_cnt;
    int                valid_cyc;
    logic [NUM_CH-1:0] exp_grant_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [1:0]        exp_sel_q[$];

    initial begin
        clk_1M = 1'b0;
        forever #500 clk_1M = ~clk_1M;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_1M);
            cyc++;
        end
    end

    // ADC: answers adc_delay cycles after each adc_start while enabled.
    initial begin
        adc_done  = 1'b0;
        adc_data  = '0;
        cd        = 0;
        start_cnt = 0;
        start_cyc = 0;
        forever begin
            @(negedge clk_1M);
            adc_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    adc_done = 1'b1;
                    if (adc_q.size() > 0) adc_data = adc_q.pop_front();
                    else adc_data = '0;
                end
            end
            if (adc_start) begin
                start_cnt++;
                start_cyc = cyc;
                start_sel_q.push_back(adc_mux_sel);
                if (adc_en) cd = adc_delay - 1;
            end
        end
    end

    initial begin
        valid_cnt = 0;
        valid_cyc = 0;
        forever begin
            @(negedge clk_1M);
            if (ch_valid) begin
                obs_grant_q.push_back(ch_grant);
                obs_data_q.push_back(ch_data);
                valid_cnt++;
                valid_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk_1M);
        #1;
    endtask

    task automatic clear_queues();
        adc_q.delete();
        start_sel_q.delete();
        obs_grant_q.delete();
        obs_data_q.delete();
        exp_grant_q.delete();
        exp_data_q.delete();
        exp_sel_q.delete();
    endtask

    // Queues N_CONV random samples for one grant and the expected averaged result.
    task automatic push_grant(input int ch);
        int sum;
        logic [DATA_W-1:0] d;
        sum = 0;
        for (int k = 0; k < N_CONV; k++) begin
            d = DATA_W'($urandom_range(0, 4095));
            sum += int'(d);
            adc_q.push_back(d);
            exp_sel_q.push_back(2'(ch));
        end
        exp_grant_q.push_back(NUM_CH'(1) << ch);
        exp_data_q.push_back(DATA_W'(sum / N_CONV));
    endtask

    int t_start;

    task automatic test_reset();
        rst_n = 1'b0; ch_req = '0; err_clr = 1'b0; adc_en = 1'b0; adc_delay = 4;
        repeat (3) tick();
        checks++; if (ch_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", ch_grant); end
        checks++; if (ch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ch_valid); end
        checks++; if (ch_data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", ch_data); end
        checks++; if (adc_mux_sel !== 2'd0) begin errors++; $display("FAIL reset_mux: got %0d expected 0", adc_mux_sel); end
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", adc_start); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    endtask

    task automatic test_startup();
        int base, s0, n;
        clear_queues();
        adc_en = 1'b1; adc_delay = 4;
        repeat (N_CONV) adc_q.push_back(12'h5A3);
        exp_grant_q.push_back(4'b0001);
        exp_data_q.push_back(12'h5A3);
        ch_req = 4'b0001;
        s0 = start_cnt;
        base = cyc;
        rst_n = 1'b1;
        n = 0;
        while (start_cnt == s0 && n < 400) begin tick(); n++; end
        checks++;
        if (start_cnt == s0) begin
            errors++; $display("FAIL startup_start: no adc_start within %0d cycles", n);
        end else if (start_cyc - base !== 254) begin
            errors++; $display("FAIL startup_start: first adc_start at cycle %0d expected 254", start_cyc - base);
        end
        t_start = start_cyc;
        checks++; if (start_sel_q.size() == 0 || start_sel_q[0] !== 2'd0) begin errors++; $display("FAIL startup_mux: first start not on channel 0"); end
    endtask

    task automatic test_basic();
        int n, v0;
        logic [NUM_CH-1:0] eg;
        logic [DATA_W-1:0] ed;
        v0 = valid_cnt;
        n = 0;
        while (obs_grant_q.size() == 0 && n < 100) begin tick(); n++; end
        ch_req = '0;
        checks++;
        if (obs_grant_q.size() == 0) begin
            errors++; $display("FAIL basic_valid: no ch_valid within %0d cycles", n);
        end else begin
            eg = exp_grant_q.pop_front();
            ed = exp_data_q.pop_front();
            if (obs_grant_q[0] !== eg) begin errors++; $display("FAIL basic_grant: got %b expected %b", obs_grant_q[0], eg); end
            checks++; if (obs_data_q[0] !== ed) begin errors++; $display("FAIL basic_data: got %h expected %h", obs_data_q[0], ed); end
            checks++; if (valid_cyc - t_start !== 4 * N_CONV) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", valid_cyc - t_start, 4 * N_CONV); end
        end
        repeat (5) tick();
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (ch_data !== 12'h5A3) begin errors++; $display("FAIL basic_hold: got %h expected 5a3", ch_data); end
        checks++; if (ch_grant !== 4'b0000 || ch_valid !== 1'b0) begin errors++; $display("FAIL basic_strobe_low: grant %b valid %b expected 0000 0", ch_grant, ch_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int order[6];
        int n;
        logic [NUM_CH-1:0] eg;
        logic [DATA_W-1:0] ed;
        logic [1:0] es;
        order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0; order[4] = 1; order[5] = 3;
        rst_n = 1'b0; ch_req = '0;
        repeat (2) tick();
        clear_queues();
        adc_en = 1'b1; adc_delay = 3;
        for (int i = 0; i < 6; i++) push_grant(order[i]);
        ch_req = 4'b1011;
        rst_n = 1'b1;
        n = 0;
        while (obs_grant_q.size() < 6 && n < 1500) begin tick(); n++; end
        ch_req = '0;
        repeat (4) tick();
        checks++;
        if (obs_grant_q.size() != 6) begin
            errors++; $display("FAIL rr_count: got %0d deliveries expected 6", obs_grant_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                eg = exp_grant_q.pop_front();
                ed = exp_data_q.pop_front();
                checks++; if (obs_grant_q[i] !== eg) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, obs_grant_q[i], eg); end
                checks++; if (obs_data_q[i] !== ed) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, obs_data_q[i], ed); end
            end
            checks++;
            if (start_sel_q.size() != 6 * N_CONV) begin
                errors++; $display("FAIL rr_starts: got %0d expected %0d", start_sel_q.size(), 6 * N_CONV);
            end else begin
                for (int i = 0; i < 6 * N_CONV; i++) begin
                    es = exp_sel_q.pop_front();
                    checks++; if (start_sel_q[i] !== es) begin errors++; $display("FAIL rr_mux[%0d]: got %0d expected %0d", i, start_sel_q[i], es); end
                end
            end
        end
    endtask

    task automatic test_timeout();
        int s0, v0, n, t;
        clear_queues();
        adc_en = 1'b0;
        ch_req = 4'b0100;
        s0 = start_cnt;
        v0 = valid_cnt;
        n = 0;
        while (start_cnt == s0 && n < 20) begin tick(); n++; end
        t = start_cyc;
        ch_req = 4'b0101;
        checks++; if (start_cnt == s0 || start_sel_q.size() == 0 || start_sel_q[0] !== 2'd2) begin errors++; $display("FAIL to_first_sel: channel 2 conversion not started"); end
        while (cyc < t + 63) tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0 at cycle 63", timeout_err); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1 at cycle 64", timeout_err); end
        adc_en = 1'b1; adc_delay = 4;
        start_sel_q.delete();
        push_grant(0);
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL to_no_valid: got %0d deliveries expected 0", valid_cnt - v0); end
        n = 0;
        while (start_sel_q.size() == 0 && n < 20) begin tick(); n++; end
        checks++; if (start_sel_q.size() == 0 || start_sel_q[0] !== 2'd0) begin errors++; $display("FAIL to_next_winner: next conversion not on channel 0"); end
        n = 0;
        while (obs_grant_q.size() == 0 && n < 100) begin tick(); n++; end
        ch_req = '0;
        checks++;
        if (obs_grant_q.size() == 0) begin
            errors++; $display("FAIL to_next_valid: no delivery within %0d cycles", n);
        end else begin
            if (obs_grant_q[0] !== exp_grant_q[0]) begin errors++; $display("FAIL to_next_grant: got %b expected %b", obs_grant_q[0], exp_grant_q[0]); end
            checks++; if (obs_data_q[0] !== exp_data_q[0]) begin errors++; $display("FAIL to_next_data: got %h expected %h", obs_data_q[0], exp_data_q[0]); end
        end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout_err); end
    endtask

    task automatic test_reset_mid_convert();
        int s0, v0, s1, n;
        clear_queues();
        adc_en = 1'b1; adc_delay = 3;
        repeat (N_CONV) adc_q.push_back(12'h777);
        ch_req = 4'b0010;
        s0 = start_cnt;
        v0 = valid_cnt;
        n = 0;
        while (start_cnt == s0 && n < 20) begin tick(); n++; end
        checks++; if (start_cnt == s0) begin errors++; $display("FAIL rmc_start: no adc_start within %0d cycles", n); end
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (ch_grant !== 4'b0000 || ch_valid !== 1'b0 || adc_start !== 1'b0) begin errors++; $display("FAIL rmc_strobes: grant %b valid %b start %b expected 0000 0 0", ch_grant, ch_valid, adc_start); end
        checks++; if (ch_data !== 12'h000 || adc_mux_sel !== 2'd0) begin errors++; $display("FAIL rmc_data_mux: data %h mux %0d expected 000 0", ch_data, adc_mux_sel); end
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rmc_flags: terr %b busy %b expected 0 1", timeout_err, busy); end
        repeat (2) tick();
        rst_n = 1'b1;
        s1 = start_cnt;
        repeat (20) tick();
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL rmc_no_valid: got %0d deliveries expected 0", valid_cnt - v0); end
        checks++; if (start_cnt !== s1 || busy !== 1'b1) begin errors++; $display("FAIL rmc_startup: starts %0d busy %b expected 0 1", start_cnt - s1, busy); end
        checks++; if (ch_data !== 12'h000) begin errors++; $display("FAIL rmc_late_done: got %h expected 000", ch_data); end
        ch_req = '0;
    endtask

`ifdef ADC_SEQ_AVG4_EN
    task automatic test_avg4();
        int s0, v0, n;
        rst_n = 1'b0; ch_req = '0;
        repeat (2) tick();
        clear_queues();
        adc_en = 1'b1; adc_delay = 4;
        adc_q.push_back(12'd100); adc_q.push_back(12'd101);
        adc_q.push_back(12'd102); adc_q.push_back(12'd104);
        s0 = start_cnt;
        v0 = valid_cnt;
        ch_req = 4'b0001;
        rst_n = 1'b1;
        n = 0;
        while (obs_data_q.size() == 0 && n < 600) begin tick(); n++; end
        ch_req = '0;
        repeat (5) tick();
        checks++; if (start_cnt - s0 !== 4) begin errors++; $display("FAIL avg_starts: got %0d expected 4", start_cnt - s0); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL avg_valids: got %0d expected 1", valid_cnt - v0); end
        checks++; if (ch_data !== 12'd101) begin errors++; $display("FAIL avg_data: got %0d expected 101", ch_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_startup();
        test_basic();
        test_round_robin();
        test_timeout();
        test_reset_mid_convert();
`ifdef ADC_SEQ_AVG4_EN
        test_avg4();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_channel_sequencer.md
Name: adc_channel_sequencer

Overview:
- Shares the single on-board 12-bit ADC between up to NUM_CH consumers: battery-voltage averaging filter, output-voltage monitor, current sense and temperature.
- Holds off all conversions for a start-up window while the converter output settles.
- Arbitrates pending requests round-robin, drives the ADC mux select, waits a settle time, then runs a start/done handshake with the ADC.
- Returns each result to the requester with a one-cycle valid/grant strobe.

Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- DATA_W, 12: ADC result width.
- STARTUP_CYC, 250: clk_1M cycles held in STARTUP after reset.
- SETTLE_CYC, 3: cycles between a mux_sel change and adc_start.
- TIMEOUT_CYC, 64: cycles allowed from adc_start to adc_done.

Ports:
- clk_1M  in  1  system clock, 1 MHz.
- rst_n  in  1  synchronous, active-low reset.
- ch_req  in  NUM_CH  per-channel sample request, level; bit i = channel i.
- ch_grant  out  NUM_CH  one-hot; high for exactly the ch_valid cycle.
- ch_valid  out  1  one-cycle strobe: ch_data is valid for the granted channel.
- ch_data  out  DATA_W  conversion result, held until the next delivery.
- adc_mux_sel  out  clog2(NUM_CH)  analog mux channel select.
- adc_start  out  1  one-cycle conversion start pulse.
- adc_done  in  1  conversion complete, one-cycle pulse from the ADC.
- adc_data  in  DATA_W  ADC result; valid in the adc_done cycle.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky; set when an ADC conversion times out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk_1M edge):
  - Outputs: ch_grant=0, ch_valid=0, ch_data=0, adc_mux_sel=0, adc_start=0, timeout_err=0, busy=1.
  - Round-robin pointer set to NUM_CH-1, so channel 0 has first priority.
  - State = STARTUP. Reset mid-conversion aborts it: no grant, and any late adc_done is ignored.
- STARTUP: count STARTUP_CYC cycles, then go to IDLE. Requests are not sampled in this state.
- IDLE:
  - If any ch_req bit is set, pick the first set bit searching from pointer+1, wrapping modulo NUM_CH.
  - Register the winner, set adc_mux_sel=winner, go to SETTLE.
  - If nothing is requested, stay in IDLE.
- SETTLE: wait SETTLE_CYC cycles, then go to CONVERT.
- CONVERT:
  - adc_start=1 on the first CONVERT cycle only.
  - adc_done is sampled from the following cycle onward; an adc_done coincident with adc_start is ignored.
  - On adc_done: capture adc_data into ch_data and go to DELIVER.
  - If TIMEOUT_CYC cycles pass after adc_start with no adc_done: set timeout_err, set pointer=winner, return to IDLE with no delivery.
- DELIVER (one cycle):
  - ch_valid=1 and ch_grant=onehot(winner).
  - Pointer=winner, then go to IDLE.
- Minimum request-to-valid latency is 1+SETTLE_CYC+1+conversion cycles.
- A winner whose ch_req drops after selection is still converted and delivered.
- Requesters hold ch_req until they see their grant.
- err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- An adc_done seen outside CONVERT is ignored.

Optional Feature:
- Macro: ADC_SEQ_AVG4_EN.
- Defined:
  - Each grant runs 4 back-to-back conversions on the same channel; SETTLE is done only once.
  - adc_start for conversion k+1 pulses the cycle after adc_done of conversion k.
  - Results are summed in a DATA_W+2-bit accumulator. ch_data = sum>>2 (truncating).
  - A timeout on any of the 4 conversions aborts the whole grant.
- Undefined: single conversion per grant, as above.

Decomposition:
- Package adc_seq_pkg holds:
  - the state enum: STARTUP, IDLE, SETTLE, CONVERT, DELIVER;
  - the DATA_W and counter-width localparams;
  - a clog2 constant function.
- Sub-module rr_arbiter_pick: combinational; inputs req and ptr, outputs winner index and found flag. It is reusable for the PWM-source arbitration.

Test Plan:
- Startup hold: ch_req=4'b0001 from reset release → first adc_start exactly 250+1+3 cycles after the first non-reset edge; no earlier adc_start.
- Basic delivery: ADC returns 12'h5A3 four cycles after adc_start → ch_valid for 1 cycle, ch_grant=4'b0001, ch_data=12'h5A3 held afterward.
- Round-robin: ch_req=4'b1011 held → grant order 0,1,3,0,1,3; adc_mux_sel matches each grant.
- Timeout: ch_req=4'b0100, adc_done never asserted → timeout_err=1 at cycle 64 after adc_start, no ch_valid, next winner is not 2 if others are pending. err_clr=1 → timeout_err=0.
- Reset mid-CONVERT: rst_n=0 two cycles after adc_start, adc_done arrives next cycle → no ch_valid, state STARTUP, all outputs at reset values.
- ADC_SEQ_AVG4_EN: results 100, 101, 102, 104 → exactly 4 adc_start pulses, one ch_valid, ch_data=101.
